// File: rtl/button_conditioner.sv
// Synchronise, debounce and arbitrate four colour buttons into a one-hot held level plus strobes.
// Optional `BTN_COND_ACTIVE_LOW_EN` selects pull-up (idle-high) buttons.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_held,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       multi_err
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HELD, LOCKOUT} state_t;

  logic [3:0]         sync1_q, sync1_d;
  logic [3:0]         sync2_q, sync2_d;
  logic [3:0]         btn_lvl;
  logic [3:0]         db_q, db_d;
  logic [3:0][CW-1:0] cnt_q, cnt_d;
  logic               db_none, db_one;

  state_t             state_q;
  logic [3:0]         held_q;
  logic               press_q, release_q, err_q;

  // Sync flops carry the pin level so an idle-high pin resets to its idle value;
  // the polarity flip happens on the synchronised level.
`ifdef BTN_COND_ACTIVE_LOW_EN
  localparam logic [3:0] SYNC_RST = 4'hF;
  assign btn_lvl = ~sync2_q;
`else
  localparam logic [3:0] SYNC_RST = 4'h0;
  assign btn_lvl = sync2_q;
`endif

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (btn_lvl[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) db_d[i]  = ~db_q[i];
        else                      cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
      db_q    <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_none = (db_q == 4'b0000);
  assign db_one  = !db_none && ((db_q & (db_q - 4'd1)) == 4'b0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      held_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (db_one) begin
            held_q  <= db_q;
            press_q <= 1'b1;
            state_q <= HELD;
          end else if (!db_none) begin
            err_q   <= 1'b1;
            state_q <= LOCKOUT;
          end
        end
        HELD: begin
          if ((db_q & held_q) == 4'b0000) begin
            release_q <= 1'b1;
            held_q    <= '0;
            state_q   <= db_none ? IDLE : LOCKOUT;
          end
        end
        LOCKOUT: begin
          held_q <= '0;
          if (db_none) state_q <= IDLE;
        end
        default: begin
          held_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign btn_held      = held_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign multi_err     = err_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4; event offsets are edges
// counted from the first edge that samples the new input (press expected at offset 6).
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] btn_held;
  logic       press_pulse, release_pulse, multi_err;

  int n_cmp  = 0;
  int n_fail = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .btn_held     (btn_held),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .multi_err    (multi_err)
  );

  always #5 clk = ~clk;

  // Step n edges, sampling 1 time unit after each; offsets are 0-based from the first edge.
  task automatic observe(input int n,
                         output int fp, output int fr, output int fe,
                         output int np, output int nr, output int ne,
                         output logic [3:0] held_at_press, output logic [3:0] held_any,
                         output logic [3:0] held_end, output bit bad);
    fp = -1; fr = -1; fe = -1; np = 0; nr = 0; ne = 0;
    held_at_press = 'x; held_any = '0; bad = 1'b0;
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      if (press_pulse)   begin np++; if (fp < 0) begin fp = j; held_at_press = btn_held; end end
      if (release_pulse) begin nr++; if (fr < 0) fr = j; end
      if (multi_err)     begin ne++; if (fe < 0) fe = j; end
      held_any |= btn_held;
      if ((int'(press_pulse) + int'(release_pulse) + int'(multi_err)) > 1) bad = 1'b1;
      if ((btn_held & (btn_held - 4'd1)) != 4'b0000) bad = 1'b1;
    end
    held_end = btn_held;
  endtask

  int         fp, fr, fe, np, nr, ne;
  logic [3:0] hp, ha, he;
  bit         bad;

  task automatic test_reset();
    rst = 1'b1; btn_raw = 4'b0010;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({btn_held, press_pulse, release_pulse, multi_err} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %b, want 0000000", j,
                 {btn_held, press_pulse, release_pulse, multi_err});
      end
    end
    rst = 1'b0;
    observe(10, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
    n_cmp++; if (fp !== 6)          begin n_fail++; $display("FAIL reset_press_offset: got %0d, want 6", fp); end
    n_cmp++; if (hp !== 4'b0010)    begin n_fail++; $display("FAIL reset_press_held: got %b, want 0010", hp); end
    n_cmp++; if (np !== 1 || ne !== 0 || bad) begin n_fail++; $display("FAIL reset_press_count: np=%0d ne=%0d bad=%0b, want 1 0 0", np, ne, bad); end
    btn_raw = 4'b0000;
    observe(10, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
    n_cmp++; if (fr !== 6 || nr !== 1) begin n_fail++; $display("FAIL reset_release: offset=%0d count=%0d, want 6 1", fr, nr); end
  endtask

  task automatic test_clean_press();
    btn_raw = 4'b0001;
    observe(20, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
    n_cmp++; if (fp !== 6)          begin n_fail++; $display("FAIL clean_press_offset: got %0d, want 6", fp); end
    n_cmp++; if (hp !== 4'b0001 || he !== 4'b0001) begin n_fail++; $display("FAIL clean_press_held: at_press=%b end=%b, want 0001", hp, he); end
    n_cmp++; if (np !== 1 || nr !== 0 || ne !== 0 || bad) begin n_fail++; $display("FAIL clean_press_strobes: p=%0d r=%0d e=%0d bad=%0b, want 1 0 0 0", np, nr, ne, bad); end
    btn_raw = 4'b0000;
    observe(10, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
    n_cmp++; if (fr !== 6 || nr !== 1) begin n_fail++; $display("FAIL clean_release: offset=%0d count=%0d, want 6 1", fr, nr); end
    n_cmp++; if (he !== 4'b0000)    begin n_fail++; $display("FAIL clean_release_held: got %b, want 0000", he); end
  endtask

  task automatic test_glitch();
    int tot = 0;
    logic [3:0] any = '0;
    for (int r = 0; r < 5; r++) begin
      btn_raw = 4'b0100;
      observe(3, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
      tot += np + nr + ne; any |= ha;
      btn_raw = 4'b0000;
      observe(1, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
      tot += np + nr + ne; any |= ha;
    end
    observe(10, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
    tot += np + nr + ne; any |= ha;
    n_cmp++; if (tot !== 0)         begin n_fail++; $display("FAIL glitch_strobes: got %0d, want 0", tot); end
    n_cmp++; if (any !== 4'b0000)   begin n_fail++; $display("FAIL glitch_held: got %b, want 0000", any); end
  endtask

  // Exactly DEBOUNCE_CYCLES stable cycles is enough to be accepted.
  task automatic test_boundary();
    btn_raw = 4'b0001;
    observe(4, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
    btn_raw = 4'b0000;
    observe(12, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
    n_cmp++; if (fp !== 2 || np !== 1) begin n_fail++; $display("FAIL boundary_press: offset=%0d count=%0d, want 2 1", fp, np); end
    n_cmp++; if (fr !== 6 || nr !== 1) begin n_fail++; $display("FAIL boundary_release: offset=%0d count=%0d, want 6 1", fr, nr); end
  endtask

  task automatic test_simultaneous();
    btn_raw = 4'b1100;
    observe(20, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
    n_cmp++; if (fe !== 6 || ne !== 1) begin n_fail++; $display("FAIL simul_err: offset=%0d count=%0d, want 6 1", fe, ne); end
    n_cmp++; if (np !== 0 || nr !== 0 || ha !== 4'b0000) begin n_fail++; $display("FAIL simul_quiet: p=%0d r=%0d held=%b, want 0 0 0000", np, nr, ha); end
    btn_raw = 4'b0000;
    observe(10, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
    n_cmp++; if (np + nr + ne !== 0 || ha !== 4'b0000) begin n_fail++; $display("FAIL simul_release: strobes=%0d held=%b, want 0 0000", np + nr + ne, ha); end
    btn_raw = 4'b1000;
    observe(10, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
    n_cmp++; if (fp !== 6 || hp !== 4'b1000) begin n_fail++; $display("FAIL simul_next_press: offset=%0d held=%b, want 6 1000", fp, hp); end
    btn_raw = 4'b0000;
    observe(10, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
  endtask

  task automatic test_overlap();
    btn_raw = 4'b0010;
    observe(10, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
    n_cmp++; if (fp !== 6 || hp !== 4'b0010) begin n_fail++; $display("FAIL overlap_first: offset=%0d held=%b, want 6 0010", fp, hp); end
    btn_raw = 4'b1010;
    observe(10, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
    n_cmp++; if (np + nr + ne !== 0 || ha !== 4'b0010 || he !== 4'b0010 || bad) begin n_fail++; $display("FAIL overlap_hold: strobes=%0d any=%b end=%b, want 0 0010 0010", np + nr + ne, ha, he); end
    btn_raw = 4'b1000;
    observe(10, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
    n_cmp++; if (fr !== 6 || np !== 0 || ne !== 0 || he !== 4'b0000) begin n_fail++; $display("FAIL overlap_release1: r_off=%0d p=%0d e=%0d held=%b, want 6 0 0 0000", fr, np, ne, he); end
    btn_raw = 4'b0000;
    observe(10, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
    n_cmp++; if (np + nr + ne !== 0 || ha !== 4'b0000) begin n_fail++; $display("FAIL overlap_release3: strobes=%0d held=%b, want 0 0000", np + nr + ne, ha); end
  endtask

  task automatic test_mid_reset();
    btn_raw = 4'b0100;
    observe(10, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
    n_cmp++; if (fp !== 6 || hp !== 4'b0100) begin n_fail++; $display("FAIL midrst_first: offset=%0d held=%b, want 6 0100", fp, hp); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({btn_held, press_pulse, release_pulse, multi_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL midrst_clear: got %b, want 0000000", {btn_held, press_pulse, release_pulse, multi_err});
    end
    rst = 1'b0;
    observe(12, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
    n_cmp++; if (fp !== 6 || np !== 1 || hp !== 4'b0100) begin n_fail++; $display("FAIL midrst_repress: offset=%0d count=%0d held=%b, want 6 1 0100", fp, np, hp); end
    n_cmp++; if (nr !== 0 || ne !== 0) begin n_fail++; $display("FAIL midrst_no_strobe: r=%0d e=%0d, want 0 0", nr, ne); end
    btn_raw = 4'b0000;
    observe(10, fp, fr, fe, np, nr, ne, hp, ha, he, bad);
    n_cmp++; if (fr !== 6 || he !== 4'b0000) begin n_fail++; $display("FAIL midrst_release: offset=%0d held=%b, want 6 0000", fr, he); end
  endtask

  initial begin
    rst = 1'b1;
    btn_raw = 4'b0000;
    test_reset();
    test_clean_press();
    test_glitch();
    test_boundary();
    test_simultaneous();
    test_overlap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
